// File: rtl/cond_flag_unit_pkg.sv
// Shared flag/condition types and encodings for the NZCV consumer and its
// condition evaluator (also used by the CSEL/CCMP datapaths).
package cond_flag_unit_pkg;

  typedef logic [3:0] flag_bus_t;
  typedef logic [3:0] cond_bus_t;

  // Flag bit positions inside an NZVC bus
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_C = 0;

  localparam logic TRUE_V  = 1'b1;
  localparam logic FALSE_V = 1'b0;

  // ARMv8 condition field encodings
  localparam cond_bus_t COND_EQ = 4'b0000;
  localparam cond_bus_t COND_NE = 4'b0001;
  localparam cond_bus_t COND_CS = 4'b0010;
  localparam cond_bus_t COND_CC = 4'b0011;
  localparam cond_bus_t COND_MI = 4'b0100;
  localparam cond_bus_t COND_PL = 4'b0101;
  localparam cond_bus_t COND_VS = 4'b0110;
  localparam cond_bus_t COND_VC = 4'b0111;
  localparam cond_bus_t COND_HI = 4'b1000;
  localparam cond_bus_t COND_LS = 4'b1001;
  localparam cond_bus_t COND_GE = 4'b1010;
  localparam cond_bus_t COND_LT = 4'b1011;
  localparam cond_bus_t COND_GT = 4'b1100;
  localparam cond_bus_t COND_LE = 4'b1101;
  localparam cond_bus_t COND_AL = 4'b1110;
  localparam cond_bus_t COND_NV = 4'b1111;

endpackage

// File: rtl/cond_flag_unit_cond_eval.sv
// Purely combinational ARMv8 condition-code evaluator: (cond, nzcv) -> pass.
module cond_eval
  import cond_flag_unit_pkg::*;
(
  input  logic [3:0] cond_i,
  input  logic [3:0] nzcv_i,
  output logic       pass_o
);

  logic w_n;
  logic w_z;
  logic w_v;
  logic w_c;
  logic w_base;

  assign w_n = nzcv_i[FLAG_N];
  assign w_z = nzcv_i[FLAG_Z];
  assign w_v = nzcv_i[FLAG_V];
  assign w_c = nzcv_i[FLAG_C];

  // Even codes test a base predicate; odd codes invert it, except AL/NV which always pass
  always_comb begin
    w_base = TRUE_V;
    case (cond_i[3:1])
      3'b000:  w_base = w_z;
      3'b001:  w_base = w_c;
      3'b010:  w_base = w_n;
      3'b011:  w_base = w_v;
      3'b100:  w_base = w_c & ~w_z;
      3'b101:  w_base = (w_n == w_v);
      3'b110:  w_base = ~w_z & (w_n == w_v);
      default: w_base = TRUE_V;
    endcase
    if (cond_i[3:1] == 3'b111) begin
      pass_o = TRUE_V;
    end else begin
      pass_o = w_base ^ cond_i[0];
    end
  end

endmodule

// File: rtl/cond_flag_unit.sv
// Architectural NZCV register, in-flight flag-setter tracking, and a
// registered condition-query response channel.
module cond_flag_unit
  import cond_flag_unit_pkg::*;
#(
  parameter int CNT_W = 2,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flags_we_i,
  input  logic [3:0]       flags_i,
  input  logic             fs_issue_i,
  input  logic             flush_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [3:0]       cond_i,
  input  logic [TAG_W-1:0] req_tag_i,
  output logic             resp_valid_o,
  input  logic             resp_ready_i,
  output logic             cond_pass_o,
  output logic [TAG_W-1:0] resp_tag_o,
  output logic [3:0]       nzcv_o,
  output logic             pending_o,
  output logic             err_o
);

  localparam logic [CNT_W-1:0] CNT_ZERO = '0;
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [3:0]       r_nzcv;
  logic [CNT_W-1:0] r_cnt;
  logic             r_err;
  logic             r_resp_valid;
  logic             r_pass;
  logic [TAG_W-1:0] r_tag;

  flag_bus_t w_eff;
  logic      w_dep_ok;
  logic      w_accept;
  logic      w_pass;
  logic      w_ovf;
  logic      w_udf;

  // Current writeback is forwarded to a same-cycle query
  assign w_eff = flags_we_i ? flags_i : r_nzcv;

  // Flags are final when nothing is in flight, or the last in-flight setter writes back now
  assign w_dep_ok = (r_cnt == CNT_ZERO) |
                    ((r_cnt == CNT_ONE) & flags_we_i & ~fs_issue_i);

  assign req_ready_o = w_dep_ok & ~flush_i & (~r_resp_valid | resp_ready_i);
  assign w_accept    = req_valid_i & req_ready_o;

  // Saturation / underflow events; flush takes priority and suppresses both
  assign w_ovf = ~flush_i & fs_issue_i & ~flags_we_i & (r_cnt == CNT_MAX);
  assign w_udf = ~flush_i & flags_we_i & ~fs_issue_i & (r_cnt == CNT_ZERO);

  cond_eval u_cond_eval (
    .cond_i (cond_i),
    .nzcv_i (w_eff),
    .pass_o (w_pass)
  );

  // Architectural flags: writeback is from an older op, so flush does not block it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_nzcv <= 4'b0000;
    end else if (flags_we_i) begin
      r_nzcv <= flags_i;
    end
  end

  // In-flight flag-setter counter with saturation at both ends
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= CNT_ZERO;
    end else if (flush_i) begin
      r_cnt <= CNT_ZERO;
    end else if (fs_issue_i && flags_we_i) begin
      r_cnt <= r_cnt;
    end else if (fs_issue_i) begin
      if (r_cnt != CNT_MAX) r_cnt <= r_cnt + CNT_ONE;
    end else if (flags_we_i) begin
      if (r_cnt != CNT_ZERO) r_cnt <= r_cnt - CNT_ONE;
    end
  end

  // Sticky counter error, cleared only by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err <= FALSE_V;
    end else if (w_ovf || w_udf) begin
      r_err <= TRUE_V;
    end
  end

  // Response register: load on accept, hold under backpressure, drop on release or flush
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_resp_valid <= FALSE_V;
      r_pass       <= FALSE_V;
      r_tag        <= '0;
    end else if (flush_i) begin
      r_resp_valid <= FALSE_V;
    end else if (w_accept) begin
      r_resp_valid <= TRUE_V;
      r_pass       <= w_pass;
      r_tag        <= req_tag_i;
    end else if (resp_ready_i) begin
      r_resp_valid <= FALSE_V;
    end
  end

  assign nzcv_o       = r_nzcv;
  assign pending_o    = (r_cnt != CNT_ZERO);
  assign err_o        = r_err;
  assign resp_valid_o = r_resp_valid;
  assign cond_pass_o  = r_pass;
  assign resp_tag_o   = r_tag;

endmodule

// File: doc/cond_flag_unit.md
Name: cond_flag_unit

Overview:
- Consumer end of the ALU flag interface: holds the architectural NZCV register and evaluates ARMv8 condition codes against it for B.cond, CSEL and CCMP.
- Tracks flag-setting instructions still in flight between issue and ALU writeback, and stalls condition queries until the flags they depend on are final.
- Results return to the branch/select logic over a registered valid/ready response channel.

Parameters:
- CNT_W, 2: width of the in-flight flag-setter counter; maximum count is 2^CNT_W-1.
- TAG_W, 4: width of the request tag echoed with each response.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- flags_we_i  in  1  ALU writeback of a flag-setting op this cycle.
- flags_i  in  4  NZVC (bit3 N, bit2 Z, bit1 V, bit0 C). C uses ARM semantics: C=1 means no borrow on subtract.
- fs_issue_i  in  1  a flag-setting op issued toward EX this cycle.
- flush_i  in  1  pipeline flush.
- req_valid_i  in  1  condition query valid.
- req_ready_o  out  1  query accepted when high together with req_valid_i.
- cond_i  in  4  ARMv8 cond field.
- req_tag_i  in  TAG_W  requester tag.
- resp_valid_o  out  1  response valid.
- resp_ready_i  in  1  consumer accepts the response.
- cond_pass_o  out  1  condition result.
- resp_tag_o  out  TAG_W  echoed tag.
- nzcv_o  out  4  architectural flags register.
- pending_o  out  1  in-flight counter is nonzero.
- err_o  out  1  sticky counter over/underflow.

Behaviour:
- Reset: nzcv_o, counter, resp_valid_o, cond_pass_o, resp_tag_o and err_o all 0. Reset is asynchronous and clears any held response, including one asserted mid-handshake.
- NZCV register: on a clock edge with flags_we_i=1, nzcv <= flags_i. flush_i does not block this write, because the writeback belongs to an older instruction.
- Counter update, in priority order:
  - flush_i: counter <= 0.
  - fs_issue_i and flags_we_i together: counter unchanged.
  - fs_issue_i alone: +1. At max the counter saturates and err_o <= 1.
  - flags_we_i alone: -1. At 0 the counter stays 0 and err_o <= 1.
  - err_o stays set until reset.
- Effective flags: eff = flags_we_i ? flags_i : nzcv. This bypass gives the current writeback to a same-cycle query.
- Dependency clear: dep_ok when counter==0, or when counter==1 and flags_we_i=1 and fs_issue_i=0.
- req_ready_o = dep_ok & ~flush_i & (~resp_valid_o | resp_ready_i). It is combinational and must not depend on req_valid_i.
- Accept (req_valid_i & req_ready_o): on the next edge, resp_valid_o <= 1, cond_pass_o <= eval(cond_i, eff), resp_tag_o <= req_tag_i. Latency is 1 cycle.
- Response hold: while resp_valid_o=1 and resp_ready_i=0, the response and tag hold stable.
- Response release: on resp_ready_i=1 with no new accept, resp_valid_o <= 0. Back-to-back accepts give one response per cycle.
- flush_i: resp_valid_o <= 0 on the next edge, and no request is accepted that cycle.
- Condition evaluation (eval):
  - 0000 EQ Z; 0001 NE !Z.
  - 0010 CS C; 0011 CC !C.
  - 0100 MI N; 0101 PL !N.
  - 0110 VS V; 0111 VC !V.
  - 1000 HI C&!Z; 1001 LS !(C&!Z).
  - 1010 GE N==V; 1011 LT N!=V.
  - 1100 GT !Z&(N==V); 1101 LE !(!Z&(N==V)).
  - 1110 AL 1; 1111 NV 1.
- pending_o = (counter != 0), registered state only.

Decomposition:
- defines.v additions: `FlagBus`; `CondBus` [3:0]; constants `COND_EQ` through `COND_NV`; flag bit indices `FLAG_N`=3, `FLAG_Z`=2, `FLAG_V`=1, `FLAG_C`=0; reuse `True_v`/`False_v`.
- One sub-module, cond_eval: purely combinational (cond, nzcv) -> pass. It is reused by CSEL/CCMP datapaths.

Test Plan:
- Reset, then query cond=EQ (0000), tag=3, with no writes -> one cycle later resp_valid_o=1, cond_pass_o=0, resp_tag_o=3; nzcv_o=0000.
- Bypass: flags_we_i=1, flags_i=0100, and query NE in the same cycle -> accepted, cond_pass_o=0; nzcv_o=0100 after the edge.
- Stall: fs_issue_i twice, then GE held valid -> req_ready_o=0 and pending_o=1. First writeback: still stalled. Second writeback flags_i=1010 in cycle k: accepted in k, cond_pass_o=1 in k+1.
- Backpressure: resp_ready_i=0 for 3 cycles with HI pending -> response and tag stable, req_ready_o=0. Raise ready -> the next request is accepted in that same cycle.
- Flush: counter=2 with a response held, assert flush_i -> counter=0, resp_valid_o=0, and the request presented that cycle is not accepted.
- Error: with CNT_W=2, 4 issues and no writebacks -> counter saturates at 3 and err_o=1 until rst. Separately, a writeback at counter 0 sets err_o.
